cmt_prf_release_module: RTL and testbench
=========================================

# cmt_prf_release_module

Commit-side release buffer that returns retired instructions' old physical register codes to the rename free list. It sits between the retire logic and the free list's four write ports (`wren_0..3` / `wr_prf_code_0..3`). It accepts up to four released codes per cycle, compacts and buffers them in order, and drives up to four free-list writes per cycle through a registered output stage. It holds the output stage while the free list cannot absorb writes.

## Interface
- `FIFO_DEPTH`, default 16: buffer entries. Must be a power of two, ≥ 8.
- `PTR_W`, default 4: log2(`FIFO_DEPTH`).
- Code width is `` `PRF_CODE_WIDTH`` (7).

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `i_rel_vld_0..3`  in  1 each  retire lane k releases an old PRF code.
- `i_rel_prf_code_0..3`  in  `` `PRF_CODE_WIDTH`` each  old PRF code for lane k.
- `o_rel_rdy`  out  1  buffer can accept a full 4-lane release this cycle.
- `i_rel_hold`  in  1  free list is stalled; the presented writes are not absorbed.
- `o_rel_wren_0..3`  out  1 each  free-list write enable, lane k.
- `o_rel_prf_code_0..3`  out  `` `PRF_CODE_WIDTH`` each  free-list write code, lane k.
- `o_rel_idle`  out  1  buffer and output stage are both empty.
- `o_rel_ovf`  out  1  sticky error: a release arrived while `o_rel_rdy`=0.

## Operation
- **Qualification:** lane k qualifies when `i_rel_vld_k`=1 and its code ≠ 0. Code 0 is the permanent x0 mapping and is never freed, so it is silently dropped.
- **Enqueue:** only when `o_rel_rdy`=1. Qualifying lanes are compacted in ascending lane order into consecutive slots starting at `wptr`.
  - `wptr` advances by the enqueue count (0–4) mod `FIFO_DEPTH`.
  - An enqueue may span the wrap point.
- **Ready:** `o_rel_rdy` = (`FIFO_DEPTH` − `count`) ≥ 4. It is derived from registered `count` only and has no combinational path from the inputs.
- **Overflow:** any `i_rel_vld_k`=1 while `o_rel_rdy`=0:
  - all lanes that cycle are dropped;
  - `count` and `wptr` are unchanged;
  - `o_rel_ovf` sets and stays set until `rst`.
- **Output stage:** four registered lanes, each holding a wren bit and a code.
  - The stage is "consumed" in any cycle where `i_rel_hold`=0. It is "free" when all wren bits are 0 or when it is consumed.
  - When free, it loads n = min(`count`, 4) oldest entries from `rptr`: wren lanes 0..n−1 = 1, lanes n..3 = 0, codes in FIFO order.
  - `rptr` advances by n and `count` decreases by n.
  - When not free (`i_rel_hold`=1 with any wren set), the stage holds its value and nothing is dequeued.
- Codes on lanes with wren=0 are don't-care; the implementation drives 0.
- **Count update:** enqueue and dequeue in the same cycle give `count_nxt` = `count` + enq − deq. `count` is `PTR_W`+1 bits wide and never exceeds `FIFO_DEPTH`.
- **No bypass:** an entry enqueued in cycle N is not eligible to be dequeued before cycle N+1.
- **Ordering:** strict FIFO order, oldest code on the lowest lane, across wrap-around and holds. No code is duplicated or lost except by overflow or the code-0 drop.
- **Idle:** `o_rel_idle` = (`count`==0) & (no output wren set).
- **Reset:**
  - `wptr`=`rptr`=`count`=0.
  - All `o_rel_wren_k`=0, all `o_rel_prf_code_k`=0.
  - `o_rel_ovf`=0, `o_rel_rdy`=1, `o_rel_idle`=1.
  - Reset mid-operation discards all buffered and staged codes. Rebuilding the free list is recovery logic's responsibility.

## Timing
- **Latency:** release presented in cycle N → earliest `o_rel_wren` in cycle N+2. Cycle N writes the FIFO; cycle N+1 loads the stage at the end of the cycle.
- **Throughput:** 4 codes/cycle sustained in and out when `i_rel_hold`=0.
- **Hold response:**
  - `i_rel_hold`=1 in cycle M keeps the cycle-M outputs unchanged in cycle M+1.
  - The first cycle with `i_rel_hold`=0 consumes them; the next group appears one cycle later.
- **Rate-matching boundary:** with `count`=4 and a 4-lane enqueue in the same cycle as a 4-lane dequeue, `count` stays 4 and `o_rel_rdy` stays 1.
- All outputs are registered or derived from registers only.

## Test plan
1. **Reset values:** assert `rst` 2 cycles → all wren 0, all codes 0, `o_rel_rdy`=1, `o_rel_idle`=1, `o_rel_ovf`=0.
2. **Basic latency:** cycle 0, vld=1111, codes 5,6,7,8, hold=0 → cycle 2: wren=1111, codes 5,6,7,8. Cycle 3: wren=0000, `o_rel_idle`=1.
3. **Compaction and code-0 drop:** vld lanes 0,2,3 with codes 9,0,12 (lane 1 invalid) → wren=1100, codes 9,12.
4. **Backpressure fill:** hold=1, 4 codes/cycle from cycle 0.
   - Stage holds codes 1–4 from cycle 2.
   - `o_rel_rdy` falls once `count`>12; `o_rel_ovf` remains 0.
   - Release hold → drains 4/cycle in order; `o_rel_rdy` returns.
5. **Wrap-around ordering:** 3 codes/cycle for 20 cycles with random hold → output sequence equals input sequence (scoreboard); every code freed exactly once.
6. **Overflow and reset mid-operation:**
   - Drive vld while `o_rel_rdy`=0 → `o_rel_ovf`=1 sticky; `count` unchanged.
   - Assert `rst` with entries buffered → next cycle all wren 0, `o_rel_idle`=1, `o_rel_ovf`=0.

Source files
------------

// File: rtl/cmt_prf_release_module.sv
// -----------------------------------------------------------------------------
// cmt_prf_release_module
//
// Commit-side release buffer. Retire hands over up to four old physical
// register codes per cycle. The buffer drops code 0, packs the remaining codes
// in order into a circular FIFO, and presents up to four of them per cycle to
// the rename free list through a registered output stage.
//
// Handshake semantics (one place, applies to every port below):
//   - Release side: a lane is offered when i_rel_vld_k=1. The whole group is
//     accepted only if o_rel_rdy=1 in that cycle. o_rel_rdy depends only on
//     registered occupancy. It is high when at least four slots are free.
//     A group offered while o_rel_rdy=0 is dropped and sets the sticky
//     o_rel_ovf flag.
//   - Free-list side: lanes with o_rel_wren_k=1 are presented to the free list.
//     They are taken in any cycle with i_rel_hold=0. While i_rel_hold=1 the
//     stage keeps its value, and nothing leaves the FIFO.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_rel_vld_0..3               release lane valid
//   i_rel_prf_code_0..3          released old PRF code per lane
//   o_rel_rdy                    room for a full 4-lane release
//   i_rel_hold                   free list stalled, presented writes not taken
//   o_rel_wren_0..3              free-list write enables (lowest lanes first)
//   o_rel_prf_code_0..3          free-list write codes (0 on idle lanes)
//   o_rel_idle                   FIFO and output stage both empty
//   o_rel_ovf                    sticky: release arrived while not ready
// -----------------------------------------------------------------------------
`ifndef PRF_CODE_WIDTH
`define PRF_CODE_WIDTH 7
`endif

module cmt_prf_release_module #(
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_W      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_rel_vld_0,
    input  logic                       i_rel_vld_1,
    input  logic                       i_rel_vld_2,
    input  logic                       i_rel_vld_3,
    input  logic [`PRF_CODE_WIDTH-1:0] i_rel_prf_code_0,
    input  logic [`PRF_CODE_WIDTH-1:0] i_rel_prf_code_1,
    input  logic [`PRF_CODE_WIDTH-1:0] i_rel_prf_code_2,
    input  logic [`PRF_CODE_WIDTH-1:0] i_rel_prf_code_3,
    output logic                       o_rel_rdy,
    input  logic                       i_rel_hold,
    output logic                       o_rel_wren_0,
    output logic                       o_rel_wren_1,
    output logic                       o_rel_wren_2,
    output logic                       o_rel_wren_3,
    output logic [`PRF_CODE_WIDTH-1:0] o_rel_prf_code_0,
    output logic [`PRF_CODE_WIDTH-1:0] o_rel_prf_code_1,
    output logic [`PRF_CODE_WIDTH-1:0] o_rel_prf_code_2,
    output logic [`PRF_CODE_WIDTH-1:0] o_rel_prf_code_3,
    output logic                       o_rel_idle,
    output logic                       o_rel_ovf
);

    localparam int CW = `PRF_CODE_WIDTH;
    localparam logic [PTR_W:0] RDY_MAX = (PTR_W+1)'(FIFO_DEPTH - 4);

    // Storage and pointers
    logic [CW-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;

    // Output stage
    logic [3:0]       wren_q;
    logic [CW-1:0]    code_q   [4];
    logic [3:0]       wren_nxt;
    logic [CW-1:0]    code_nxt [4];
    logic             ovf_q;

    // Lane vectors
    logic [3:0]       rel_vld;
    logic [CW-1:0]    rel_code [4];
    logic [3:0]       qual;
    logic [2:0]       off      [4];
    logic [2:0]       qual_cnt;
    logic [2:0]       enq_cnt;
    logic [PTR_W-1:0] wr_idx   [4];

    logic             rel_rdy;
    logic             ovf_evt;
    logic             stage_free;
    logic [2:0]       avail_n;
    logic [2:0]       deq_cnt;

    assign rel_vld     = {i_rel_vld_3, i_rel_vld_2, i_rel_vld_1, i_rel_vld_0};
    assign rel_code[0] = i_rel_prf_code_0;
    assign rel_code[1] = i_rel_prf_code_1;
    assign rel_code[2] = i_rel_prf_code_2;
    assign rel_code[3] = i_rel_prf_code_3;

    // Ready looks only at registered occupancy, so there is no path from the inputs.
    assign rel_rdy = (count <= RDY_MAX);
    assign ovf_evt = (|rel_vld) & ~rel_rdy;

    // Compaction. Each qualifying lane goes to slot wptr + (number of
    // qualifying lanes below it), so the group stays in order across the wrap.
    always_comb begin
        qual_cnt = 3'd0;
        for (int k = 0; k < 4; k++) begin
            qual[k]   = rel_vld[k] && (rel_code[k] != '0);
            off[k]    = qual_cnt;
            wr_idx[k] = wptr + PTR_W'(qual_cnt);
            if (qual[k]) begin
                qual_cnt = qual_cnt + 3'd1;
            end
        end
        enq_cnt = rel_rdy ? qual_cnt : 3'd0;
    end

    // Dequeue into the stage. Reads use the registered count, so entries
    // written this cycle are not visible until the next one.
    assign stage_free = ~(|wren_q) | ~i_rel_hold;
    assign avail_n    = (count >= (PTR_W+1)'(4)) ? 3'd4 : count[2:0];
    assign deq_cnt    = stage_free ? avail_n : 3'd0;

    always_comb begin
        wren_nxt = wren_q;
        for (int j = 0; j < 4; j++) begin
            code_nxt[j] = code_q[j];
        end
        if (stage_free) begin
            for (int j = 0; j < 4; j++) begin
                wren_nxt[j] = (3'(j) < avail_n);
                code_nxt[j] = (3'(j) < avail_n) ? mem[rptr + PTR_W'(j)] : '0;
            end
        end
    end

    assign count_nxt = count + (PTR_W+1)'(enq_cnt) - (PTR_W+1)'(deq_cnt);

    // FIFO storage is not reset. Entries are only meaningful below count.
    always_ff @(posedge clk) begin
        if (rel_rdy) begin
            for (int k = 0; k < 4; k++) begin
                if (qual[k]) begin
                    mem[wr_idx[k]] <= rel_code[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            wren_q <= '0;
            ovf_q  <= 1'b0;
            for (int j = 0; j < 4; j++) begin
                code_q[j] <= '0;
            end
        end else begin
            wptr   <= wptr + PTR_W'(enq_cnt);
            rptr   <= rptr + PTR_W'(deq_cnt);
            count  <= count_nxt;
            wren_q <= wren_nxt;
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end
            for (int j = 0; j < 4; j++) begin
                code_q[j] <= code_nxt[j];
            end
        end
    end

    assign o_rel_rdy        = rel_rdy;
    assign o_rel_idle       = (count == '0) & ~(|wren_q);
    assign o_rel_ovf        = ovf_q;
    assign o_rel_wren_0     = wren_q[0];
    assign o_rel_wren_1     = wren_q[1];
    assign o_rel_wren_2     = wren_q[2];
    assign o_rel_wren_3     = wren_q[3];
    assign o_rel_prf_code_0 = code_q[0];
    assign o_rel_prf_code_1 = code_q[1];
    assign o_rel_prf_code_2 = code_q[2];
    assign o_rel_prf_code_3 = code_q[3];

endmodule

// File: tb/tb_cmt_prf_release_module.sv
// -----------------------------------------------------------------------------
// tb_cmt_prf_release_module
//
// Directed bench for the commit release buffer. It covers reset values,
// latency, compaction with the code-0 drop, backpressure fill and drain,
// wrap-around ordering under random hold, and overflow followed by a
// mid-operation reset.
// -----------------------------------------------------------------------------
`ifndef PRF_CODE_WIDTH
`define PRF_CODE_WIDTH 7
`endif

module tb_cmt_prf_release_module;

    localparam int CW = `PRF_CODE_WIDTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          vld_0 = 0, vld_1 = 0, vld_2 = 0, vld_3 = 0;
    logic [CW-1:0] cin_0 = '0, cin_1 = '0, cin_2 = '0, cin_3 = '0;
    logic          hold = 1'b0;
    logic          rdy, idle, ovf;
    logic          wren_0, wren_1, wren_2, wren_3;
    logic [CW-1:0] cout_0, cout_1, cout_2, cout_3;

    logic [3:0]    wren_v;
    logic [CW-1:0] code_v [4];
    assign wren_v    = {wren_3, wren_2, wren_1, wren_0};
    assign code_v[0] = cout_0;
    assign code_v[1] = cout_1;
    assign code_v[2] = cout_2;
    assign code_v[3] = cout_3;

    cmt_prf_release_module #(.FIFO_DEPTH(16), .PTR_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_rel_vld_0      (vld_0),
        .i_rel_vld_1      (vld_1),
        .i_rel_vld_2      (vld_2),
        .i_rel_vld_3      (vld_3),
        .i_rel_prf_code_0 (cin_0),
        .i_rel_prf_code_1 (cin_1),
        .i_rel_prf_code_2 (cin_2),
        .i_rel_prf_code_3 (cin_3),
        .o_rel_rdy        (rdy),
        .i_rel_hold       (hold),
        .o_rel_wren_0     (wren_0),
        .o_rel_wren_1     (wren_1),
        .o_rel_wren_2     (wren_2),
        .o_rel_wren_3     (wren_3),
        .o_rel_prf_code_0 (cout_0),
        .o_rel_prf_code_1 (cout_1),
        .o_rel_prf_code_2 (cout_2),
        .o_rel_prf_code_3 (cout_3),
        .o_rel_idle       (idle),
        .o_rel_ovf        (ovf)
    );

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [CW-1:0] exp_q[$];
    logic          mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_rel(input logic [3:0] v, input logic [CW-1:0] a, input logic [CW-1:0] b,
                           input logic [CW-1:0] c, input logic [CW-1:0] d);
        {vld_3, vld_2, vld_1, vld_0} = v;
        cin_0 = a; cin_1 = b; cin_2 = c; cin_3 = d;
    endtask

    task automatic clear_rel();
        set_rel(4'b0000, '0, '0, '0, '0);
    endtask

    // When the monitor is on, the lanes presented at this edge are taken if
    // hold is low. Each taken lane is matched against the expected queue.
    // After the monitor step, advance one clock and sample 1 time unit after the edge.
    task automatic step();
        logic [CW-1:0] e;
        if (mon_en && !hold) begin
            for (int k = 0; k < 4; k++) begin
                if (wren_v[k]) begin
                    if (exp_q.size() == 0) begin
                        check("sb_extra_code", 32'(code_v[k]), 32'hffff_ffff);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_code", 32'(code_v[k]), 32'(e));
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_stage(input string tag, input logic [3:0] w, input logic [CW-1:0] a,
                               input logic [CW-1:0] b, input logic [CW-1:0] c, input logic [CW-1:0] d);
        check({tag, "_wren"}, 32'(wren_v), 32'(w));
        check({tag, "_c0"}, 32'(cout_0), 32'(a));
        check({tag, "_c1"}, 32'(cout_1), 32'(b));
        check({tag, "_c2"}, 32'(cout_2), 32'(c));
        check({tag, "_c3"}, 32'(cout_3), 32'(d));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [CW-1:0] nxt;
        logic [CW-1:0] b;

        // 1. reset values
        rst = 1'b1;
        step();
        step();
        check_stage("rst", 4'b0000, 0, 0, 0, 0);
        check("rst_rdy", 32'(rdy), 1);
        check("rst_idle", 32'(idle), 1);
        check("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        step();

        // 2. basic latency: presented in cycle 0, visible in cycle 2
        set_rel(4'b1111, 7'd5, 7'd6, 7'd7, 7'd8);
        step();
        clear_rel();
        check("lat_c1_wren", 32'(wren_v), 0);
        check("lat_c1_idle", 32'(idle), 0);
        step();
        check_stage("lat_c2", 4'b1111, 7'd5, 7'd6, 7'd7, 7'd8);
        step();
        check("lat_c3_wren", 32'(wren_v), 0);
        check("lat_c3_idle", 32'(idle), 1);

        // 3. compaction with the code-0 drop (lane1 invalid, lane2 carries code 0)
        set_rel(4'b1101, 7'd9, 7'd33, 7'd0, 7'd12);
        step();
        clear_rel();
        step();
        check_stage("cmp", 4'b0011, 7'd9, 7'd12, 0, 0);
        step();
        check("cmp_idle", 32'(idle), 1);

        // 4. backpressure fill: codes 1..20, stage pinned at 1..4
        hold = 1'b1;
        for (int g = 0; g < 5; g++) begin
            b = CW'(4 * g);
            set_rel(4'b1111, b + 7'd1, b + 7'd2, b + 7'd3, b + 7'd4);
            step();
            check("bp_rdy", 32'(rdy), (g < 4) ? 1 : 0);
            if (g >= 1) begin
                check_stage("bp_hold", 4'b1111, 7'd1, 7'd2, 7'd3, 7'd4);
            end
        end
        clear_rel();
        step();
        check_stage("bp_still", 4'b1111, 7'd1, 7'd2, 7'd3, 7'd4);
        check("bp_ovf", 32'(ovf), 0);
        hold = 1'b0;
        for (int g = 1; g < 5; g++) begin
            b = CW'(4 * g);
            step();
            check_stage("bp_drain", 4'b1111, b + 7'd1, b + 7'd2, b + 7'd3, b + 7'd4);
            check("bp_drain_rdy", 32'(rdy), 1);
        end
        step();
        check("bp_end_wren", 32'(wren_v), 0);
        check("bp_end_idle", 32'(idle), 1);

        // 5. wrap-around ordering: 3 codes per cycle, lanes alternate, random hold
        mon_en = 1'b1;
        nxt = 7'd1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            hold = ($urandom_range(0, 3) == 0);
            if (rdy) begin
                if (cyc % 2 == 0) set_rel(4'b0111, nxt, nxt + 7'd1, nxt + 7'd2, 7'd0);
                else              set_rel(4'b1110, 7'd0, nxt, nxt + 7'd1, nxt + 7'd2);
                exp_q.push_back(nxt);
                exp_q.push_back(nxt + 7'd1);
                exp_q.push_back(nxt + 7'd2);
                nxt = nxt + 7'd3;
            end else begin
                clear_rel();
            end
            step();
        end
        clear_rel();
        hold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && idle) break;
            step();
        end
        mon_en = 1'b0;
        check("wrap_q_empty", 32'(exp_q.size()), 0);
        check("wrap_idle", 32'(idle), 1);
        check("wrap_ovf", 32'(ovf), 0);

        // 6. overflow: fill with 21..40 under hold, then offer more while not ready
        hold = 1'b1;
        for (int g = 0; g < 5; g++) begin
            b = CW'(20 + 4 * g);
            set_rel(4'b1111, b + 7'd1, b + 7'd2, b + 7'd3, b + 7'd4);
            step();
        end
        check("ovf_pre_rdy", 32'(rdy), 0);
        check("ovf_pre", 32'(ovf), 0);
        set_rel(4'b1111, 7'd100, 7'd101, 7'd102, 7'd103);
        step();
        clear_rel();
        check("ovf_set", 32'(ovf), 1);
        step();
        check("ovf_sticky", 32'(ovf), 1);
        check_stage("ovf_stage", 4'b1111, 7'd21, 7'd22, 7'd23, 7'd24);
        // The drain must show exactly 25..40, which shows count was left unchanged.
        hold = 1'b0;
        for (int g = 1; g < 5; g++) begin
            b = CW'(20 + 4 * g);
            step();
            check_stage("ovf_drain", 4'b1111, b + 7'd1, b + 7'd2, b + 7'd3, b + 7'd4);
        end
        step();
        check("ovf_drain_idle", 32'(idle), 1);
        check("ovf_drain_sticky", 32'(ovf), 1);

        // reset mid-operation with codes buffered and staged
        hold = 1'b1;
        set_rel(4'b1111, 7'd50, 7'd51, 7'd52, 7'd53);
        step();
        set_rel(4'b1111, 7'd54, 7'd55, 7'd56, 7'd57);
        step();
        clear_rel();
        check_stage("mid_stage", 4'b1111, 7'd50, 7'd51, 7'd52, 7'd53);
        rst = 1'b1;
        step();
        check_stage("mid_rst", 4'b0000, 0, 0, 0, 0);
        check("mid_rst_idle", 32'(idle), 1);
        check("mid_rst_ovf", 32'(ovf), 0);
        check("mid_rst_rdy", 32'(rdy), 1);
        rst = 1'b0;
        hold = 1'b0;
        step();
        step();
        check("post_rst_wren", 32'(wren_v), 0);
        check("post_rst_idle", 32'(idle), 1);

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
